dsp_output_stage: RTL and testbench

DSP_OUTPUT_STAGE -- requirements
Module: dsp_output_stage

---
 rtl/dsp_output_stage_if.sv | 28 ++
 rtl/dsp_output_stage.sv | 114 +++++++++++
 tb/tb_dsp_output_stage.sv | 215 +++++++++++++++++++++
 3 files changed

// File: rtl/dsp_output_stage_if.sv
// Handshake bundle for dsp_output_stage: upstream MAC result in, FIFO head and status out.
interface dsp_output_stage_if #(
  parameter int unsigned OUT_W = 18,
  parameter int unsigned DEPTH = 4
) ();
  localparam int unsigned LW = $clog2(DEPTH) + 1;

  logic [47:0]      p_in;
  logic             p_valid;
  logic [OUT_W-1:0] out_data;
  logic             out_valid;
  logic             out_ready;
  logic             sat_pulse;
  logic             overflow_err;
  logic [LW-1:0]    level;

  // Environment side: produces samples and consumes the FIFO head.
  modport master (
    output p_in, p_valid, out_ready,
    input  out_data, out_valid, sat_pulse, overflow_err, level
  );

  // Output stage side.
  modport slave (
    input  p_in, p_valid, out_ready,
    output out_data, out_valid, sat_pulse, overflow_err, level
  );
endinterface

// File: rtl/dsp_output_stage.sv
// Output stage: round/shift/saturate the 48-bit MAC result, then buffer it in a small FIFO.
module dsp_output_stage #(
  parameter int unsigned SHIFT = 12,
  parameter int unsigned OUT_W = 18,
  parameter int unsigned DEPTH = 4
) (
  input logic               clk,
  input logic               rst_n,
  dsp_output_stage_if.slave bus
);
  localparam int unsigned PW = $clog2(DEPTH);
  localparam int unsigned LW = PW + 1;
  localparam logic [LW-1:0] DEPTH_L = LW'(DEPTH);

  // Half-LSB rounding constant; evaluates to zero when SHIFT is 0.
  localparam logic signed [48:0] RND  = (49'sd1 <<< SHIFT) >>> 1;
  localparam logic signed [48:0] MAXV = (49'sd1 <<< (OUT_W - 1)) - 49'sd1;
  localparam logic signed [48:0] MINV = -(49'sd1 <<< (OUT_W - 1));

  logic signed [48:0] p_ext;
  logic signed [48:0] r_full;
  logic [OUT_W-1:0]   s1_data_d;
  logic               s1_clip_d;

  logic               s1_valid_q;
  logic [OUT_W-1:0]   s1_data_q;
  logic               s1_clip_q;

  logic [OUT_W-1:0]   mem_q [DEPTH];
  logic [PW-1:0]      wr_ptr_q, rd_ptr_q, rd_nxt;
  logic [LW-1:0]      level_q, level_d;
  logic               out_valid_q;
  logic [OUT_W-1:0]   out_data_q, out_data_d;
  logic               sat_pulse_q;
  logic               ovf_q;

  logic               full, pop, wr_en;

  // Round half toward +inf in 49-bit arithmetic, then clip to the output range.
  always_comb begin
    p_ext     = {bus.p_in[47], bus.p_in};
    r_full    = (p_ext + RND) >>> SHIFT;
    s1_data_d = r_full[OUT_W-1:0];
    s1_clip_d = 1'b0;
    if (r_full > MAXV) begin
      s1_data_d = MAXV[OUT_W-1:0];
      s1_clip_d = 1'b1;
    end else if (r_full < MINV) begin
      s1_data_d = MINV[OUT_W-1:0];
      s1_clip_d = 1'b1;
    end
  end

  // Stage 1 register: rounded sample, its clip flag and a valid bit.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      s1_valid_q <= 1'b0;
      s1_data_q  <= '0;
      s1_clip_q  <= 1'b0;
    end else begin
      s1_valid_q <= bus.p_valid;
      s1_clip_q  <= bus.p_valid & s1_clip_d;
      if (bus.p_valid) s1_data_q <= s1_data_d;
    end
  end

  // FIFO control: a pop frees a slot on the same edge, so push-while-full succeeds only with a pop.
  always_comb begin
    full    = (level_q == DEPTH_L);
    pop     = out_valid_q & bus.out_ready;
    wr_en   = s1_valid_q & (~full | pop);
    level_d = level_q + LW'(wr_en) - LW'(pop);
    rd_nxt  = rd_ptr_q + PW'(1);
    // out_data is a register that mirrors the head: it follows the next stored entry after a pop,
    // takes the incoming sample when that sample becomes the head, and otherwise holds.
    out_data_d = out_data_q;
    if (pop && level_q > LW'(1))
      out_data_d = mem_q[rd_nxt];
    else if (wr_en && (level_q == '0 || (pop && level_q == LW'(1))))
      out_data_d = s1_data_q;
  end

  // Sample storage; only written by an accepted push.
  always_ff @(posedge clk) begin
    if (wr_en) mem_q[wr_ptr_q] <= s1_data_q;
  end

  // Pointers, occupancy and registered outputs.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wr_ptr_q    <= '0;
      rd_ptr_q    <= '0;
      level_q     <= '0;
      out_valid_q <= 1'b0;
      out_data_q  <= '0;
      sat_pulse_q <= 1'b0;
      ovf_q       <= 1'b0;
    end else begin
      if (wr_en) wr_ptr_q <= wr_ptr_q + PW'(1);
      if (pop)   rd_ptr_q <= rd_nxt;
      level_q     <= level_d;
      out_valid_q <= (level_d != '0);
      out_data_q  <= out_data_d;
      sat_pulse_q <= wr_en & s1_clip_q;
      ovf_q       <= ovf_q | (s1_valid_q & full & ~pop);
    end
  end

  assign bus.out_data     = out_data_q;
  assign bus.out_valid    = out_valid_q;
  assign bus.sat_pulse    = sat_pulse_q;
  assign bus.overflow_err = ovf_q;
  assign bus.level        = level_q;
endmodule

// File: tb/tb_dsp_output_stage.sv
// Bench for dsp_output_stage: directed spec cases plus random traffic against a queue-based model.
module tb_dsp_output_stage;
  localparam int unsigned SHIFT = 12;
  localparam int unsigned OUT_W = 18;
  localparam int unsigned DEPTH = 4;

  logic clk = 1'b0;
  logic rst_n;
  always #5 clk = ~clk;

  dsp_output_stage_if #(.OUT_W(OUT_W), .DEPTH(DEPTH)) bus ();

  dsp_output_stage #(.SHIFT(SHIFT), .OUT_W(OUT_W), .DEPTH(DEPTH)) dut (
    .clk  (clk),
    .rst_n(rst_n),
    .bus  (bus)
  );

  int n_assert = 0;
  int n_fail   = 0;

  // Reference model state: one pending stage value and a queue for the FIFO.
  logic   m_s1_v;
  longint m_s1_val;
  logic   m_s1_clip;
  longint mq[$];
  longint m_out;
  logic   m_sat;
  logic   m_ovf;

  function automatic void round_sat(input logic [47:0] p, output longint v, output logic c);
    longint ps, r, hi, lo;
    ps = longint'(signed'(p));
    if (SHIFT == 0) r = ps;
    else            r = (ps + (longint'(1) << (SHIFT - 1))) >>> SHIFT;
    hi = (longint'(1) << (OUT_W - 1)) - 1;
    lo = -(hi + 1);
    c  = (r > hi) || (r < lo);
    v  = (r > hi) ? hi : ((r < lo) ? lo : r);
  endfunction

  function automatic void model_clear();
    m_s1_v = 1'b0; m_s1_val = 0; m_s1_clip = 1'b0;
    mq.delete();
    m_out = 0; m_sat = 1'b0; m_ovf = 1'b0;
  endfunction

  function automatic void model_edge(input logic pv, input logic [47:0] pin, input logic rdy);
    logic   pop, full, c;
    longint v;
    pop   = (mq.size() != 0) && rdy;
    full  = (mq.size() == int'(DEPTH));
    m_sat = 1'b0;
    if (pop) void'(mq.pop_front());
    if (m_s1_v) begin
      if (full && !pop) m_ovf = 1'b1;
      else begin
        mq.push_back(m_s1_val);
        m_sat = m_s1_clip;
      end
    end
    if (mq.size() != 0) m_out = mq[0];
    m_s1_v = pv;
    if (pv) begin
      round_sat(pin, v, c);
      m_s1_val  = v;
      m_s1_clip = c;
    end
  endfunction

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_assert++;
    assert (got === exp) else begin
      n_fail++;
      $error("FAIL %s: observed 0x%0h expected 0x%0h at %0t", tag, got, exp, $time);
    end
  endtask

  task automatic check_all();
    logic [OUT_W-1:0] ed;
    ed = m_out[OUT_W-1:0];
    chk("out_valid", 32'(bus.out_valid), 32'(mq.size() != 0));
    chk("level", 32'(bus.level), 32'(mq.size()));
    chk("out_data", 32'(bus.out_data), 32'(ed));
    chk("sat_pulse", 32'(bus.sat_pulse), 32'(m_sat));
    chk("overflow_err", 32'(bus.overflow_err), 32'(m_ovf));
  endtask

  task automatic step(input logic pv, input logic [47:0] pin, input logic rdy);
    bus.p_valid = pv; bus.p_in = pin; bus.out_ready = rdy;
    @(posedge clk);
    model_edge(pv, pin, rdy);
    #1;
    check_all();
  endtask

  task automatic pulse_reset();
    @(negedge clk);
    rst_n = 1'b0; bus.p_valid = 1'b0; bus.out_ready = 1'b0;
    model_clear();
    #1;
    check_all();
    chk("rst_out_valid", 32'(bus.out_valid), 32'd0);
    chk("rst_level", 32'(bus.level), 32'd0);
    chk("rst_ovf", 32'(bus.overflow_err), 32'd0);
    @(negedge clk);
    rst_n = 1'b1;
  endtask

  function automatic logic [47:0] rand_pin();
    logic [63:0] w;
    longint lv;
    w = {$urandom, $urandom};
    case ($urandom_range(0, 3))
      0: lv = longint'(signed'(w[47:0]));
      1: lv = longint'(signed'(w[31:0]));
      2: lv = (longint'(131071) * 4096 + longint'($urandom_range(0, 8191)) - 4096)
              * (w[40] ? -1 : 1);
      default: lv = longint'(signed'(w[15:0])) * 4096 + 2048;
    endcase
    return lv[47:0];
  endfunction

  // Hard stop in case the sequence ever stalls.
  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1, "watchdog");
  end

  initial begin
    rst_n = 1'b0;
    bus.p_valid = 1'b0; bus.p_in = '0; bus.out_ready = 1'b0;
    model_clear();
    #1;
    check_all();
    chk("reset_out_data", 32'(bus.out_data), 32'd0);
    repeat (2) @(negedge clk);
    rst_n = 1'b1;

    // Rounding ties and just-below-tie, consumer stalled so all three queue up.
    step(1'b1, 48'h000000001800, 1'b0);
    step(1'b1, 48'h0000000017FF, 1'b0);
    step(1'b1, 48'hFFFFFFFFF800, 1'b0);
    step(1'b0, '0, 1'b0);
    chk("rnd_tie_pos", 32'(bus.out_data), 32'd2);
    chk("rnd_level3", 32'(bus.level), 32'd3);
    step(1'b0, '0, 1'b1);
    chk("rnd_below_tie", 32'(bus.out_data), 32'd1);
    step(1'b0, '0, 1'b1);
    chk("rnd_tie_neg", 32'(bus.out_data), 32'd0);
    step(1'b0, '0, 1'b1);
    chk("rnd_empty_hold", 32'(bus.out_valid), 32'd0);

    // Saturation both ways.
    step(1'b1, 48'h000100000000, 1'b1);
    step(1'b0, '0, 1'b1);
    chk("sat_pos_data", 32'(bus.out_data), 32'h1FFFF);
    chk("sat_pos_pulse", 32'(bus.sat_pulse), 32'd1);
    step(1'b0, '0, 1'b1);
    chk("sat_pos_pulse_end", 32'(bus.sat_pulse), 32'd0);
    step(1'b1, 48'hFFFF00000000, 1'b1);
    step(1'b0, '0, 1'b1);
    chk("sat_neg_data", 32'(bus.out_data), 32'h20000);
    chk("sat_neg_pulse", 32'(bus.sat_pulse), 32'd1);
    step(1'b0, '0, 1'b1);

    // Latency: single sample with consumer ready.
    step(1'b1, 48'h000000123456, 1'b1);
    chk("lat_edge1", 32'(bus.out_valid), 32'd0);
    step(1'b0, '0, 1'b1);
    chk("lat_edge2", 32'(bus.out_valid), 32'd1);
    step(1'b0, '0, 1'b1);
    chk("lat_edge3", 32'(bus.out_valid), 32'd0);
    chk("lat_level0", 32'(bus.level), 32'd0);

    // Overflow: DEPTH+2 samples into a stalled FIFO.
    for (int i = 0; i < int'(DEPTH) + 2; i++)
      step(1'b1, 48'(longint'(i + 1) * 4096), 1'b0);
    step(1'b0, '0, 1'b0);
    chk("ovf_level", 32'(bus.level), 32'(DEPTH));
    chk("ovf_flag", 32'(bus.overflow_err), 32'd1);
    for (int i = 0; i < int'(DEPTH) + 1; i++) step(1'b0, '0, 1'b1);

    // Reset with three entries queued.
    for (int i = 0; i < 3; i++) step(1'b1, rand_pin(), 1'b0);
    step(1'b0, '0, 1'b0);
    pulse_reset();
    step(1'b1, 48'h000000005000, 1'b1);
    step(1'b0, '0, 1'b1);
    chk("post_rst_sample", 32'(bus.out_data), 32'd5);
    step(1'b0, '0, 1'b1);

    // Full-throughput: fill, then push and pop every cycle.
    for (int i = 0; i < int'(DEPTH) + 1; i++) step(1'b1, rand_pin(), 1'b0);
    for (int i = 0; i < 12; i++) begin
      step(1'b1, rand_pin(), 1'b1);
      chk("thru_level", 32'(bus.level), 32'(DEPTH));
      chk("thru_no_drop", 32'(bus.overflow_err), 32'd0);
    end
    for (int i = 0; i < int'(DEPTH) + 2; i++) step(1'b0, '0, 1'b1);

    // Random traffic: mostly-ready, then mostly-stalled consumer.
    for (int i = 0; i < 300; i++)
      step($urandom_range(0, 3) != 0, rand_pin(), $urandom_range(0, 2) != 0);
    for (int i = 0; i < 150; i++)
      step($urandom_range(0, 1) != 0, rand_pin(), $urandom_range(0, 3) == 0);
    pulse_reset();
    for (int i = 0; i < 100; i++)
      step($urandom_range(0, 1) != 0, rand_pin(), $urandom_range(0, 1) != 0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
    $finish;
  end
endmodule
